// File: rtl/booth_seq_ctrl_if.sv
// Request/response bus between the execute-stage multiply request and the
// Booth sequential controller.
interface booth_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic                   err;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product, err
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product, err
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequencer for a combinational Booth radix-2 step stage: holds A/Q/M, runs
// WIDTH iterations and registers the signed product with an overflow flag.
module booth_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_seq_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] step_a_in,
    output logic [WIDTH-1:0] step_m,
    output logic [WIDTH:0]   step_q_in,
    input  logic [WIDTH-1:0] step_a_out,
    input  logic [WIDTH:0]   step_q_out
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH:0]       r_q;
    logic [WIDTH-1:0]     r_m;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_err_q;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_most_neg;

    // -M is not representable in WIDTH bits for this operand, so A-M overflows.
    assign w_most_neg = (bus.multiplicand == {1'b1, {(WIDTH-1){1'b0}}});

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_err_q   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= '0;
                        r_q     <= {bus.multiplier, 1'b0};
                        r_m     <= bus.multiplicand;
                        r_count <= CW'(WIDTH);
                        r_err_q <= w_most_neg;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= step_a_out;
                    r_q     <= step_q_out;
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_product <= {step_a_out, step_q_out[WIDTH:1]};
                        r_err     <= r_err_q;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign step_a_in   = r_a;
    assign step_m      = r_m;
    assign step_q_in   = r_q;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
    assign bus.err     = r_err;
endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
Sequential controller that drives the combinational Booth radix-2 step stage through WIDTH iterations to form a signed two's-complement product. It holds the A, Q and M registers, presents them to the step stage each cycle and captures the stage's shifted result on the next clock edge. It sits between the CPU execute-stage multiply request and the Booth step stage.

Parameters:
WIDTH, 4, operand width in bits; A and M are WIDTH bits, Q is WIDTH+1 bits, product is 2*WIDTH bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
multiplicand  input  WIDTH  signed M operand, captured on accepted start
multiplier  input  WIDTH  signed Q operand, captured on accepted start
step_a_in  output  WIDTH  current A register value, to step stage
step_m  output  WIDTH  held M register value, to step stage
step_q_in  output  WIDTH+1  current Q register value ({multiplier bits, q_-1}), to step stage
step_a_out  input  WIDTH  shifted A from step stage
step_q_out  input  WIDTH+1  shifted Q from step stage
busy  output  1  high whenever state is not IDLE
done  output  1  single-cycle completion pulse
product  output  2*WIDTH  signed result, registered, held until the next completion
err  output  1  valid with done; high when multiplicand was -2^(WIDTH-1)

Behaviour:
- Reset (async, rst_n low): state=IDLE, A=0, Q=0, M=0, count=0, product=0, done=0, err=0, busy=0. Any in-flight operation is discarded; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE: on start=1 at a rising edge: A<=0, Q<={multiplier,1'b0}, M<=multiplicand, count<=WIDTH, err_q<=(multiplicand==1 followed by WIDTH-1 zeros, i.e. -2^(WIDTH-1)), go RUN. With start=0, remain in IDLE.
- RUN: each edge: A<=step_a_out, Q<=step_q_out, count<=count-1. When count==1 at the edge, also load product<={step_a_out, step_q_out[WIDTH:1]} and err<=err_q, then go DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- step_a_in, step_m and step_q_in are continuous copies of the A, M and Q registers. Outside RUN they are don't-care to the step stage.
- Latency: start sampled at edge k; RUN spans edges k+1..k+WIDTH; done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after start. Next start is accepted at earliest edge k+WIDTH+2, when state is IDLE again.
- start while busy (RUN or DONE) is ignored; operands are not re-captured.
- product and err change only on the RUN->DONE transition and are held otherwise, including across idle periods and ignored starts.
- A is WIDTH bits, so A-M overflows for the most-negative multiplicand. The operation still runs its full length, but err=1 and product is unspecified. The most-negative multiplier is fully supported.
- count width is clog2(WIDTH+1). No wrap occurs because count is only decremented in RUN.

Test Plan:
- Reset, then start with multiplicand=3, multiplier=5 -> done pulses exactly 5 cycles after start edge; product=8'h0F; err=0; busy high for 5 cycles.
- multiplicand=-3 (4'hD), multiplier=5 -> product=8'hF1 (-15). multiplicand=-4, multiplier=-7 -> product=8'h1C (+28).
- multiplicand=7, multiplier=-8 (4'h8) -> product=8'hC8 (-56), err=0. multiplicand=-8, multiplier=1 -> done with err=1.
- Hold start=1 continuously with operands 2 and 3 -> operations accepted every WIDTH+2=6 cycles, each gives product=8'h06. Operands changed mid-RUN do not affect the result.
- Start 3*5, then drive rst_n low 2 cycles after start -> busy=0, done=0, product=0 immediately; no done afterwards. A new start of 1*1 then gives product=8'h01.
- Exhaustive sweep of all 256 operand pairs, excluding multiplicand=-8 -> product equals the signed reference product; err=0 throughout.
